// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM bank controller: FSM state encoding and arbiter grant encoding.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// Request/acknowledge port used by both the CPU and the DMA side of the bank controller.
interface sram_bank_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; purely combinational, the caller registers last_grant.
module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last_grant,
  output gnt_t       grant
);

  always_comb begin
    grant = last_grant;
    if (req[GNT_CPU] && req[GNT_DMA]) begin
      grant = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else if (req[GNT_DMA]) begin
      grant = GNT_DMA;
    end else if (req[GNT_CPU]) begin
      grant = GNT_CPU;
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Sequencer for a bank of bit-sliced synchronous 16Kx1 SRAMs: CPU/DMA round-robin access
// with 1-cycle write / 2-cycle read strobes, plus a post-reset INIT_VALUE sweep.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                ADDR_W        = ADDR_W_DEF,
  parameter int                DATA_W        = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
  parameter bit                INIT_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_start,
  output logic                init_busy,
  sram_bank_ctrl_if.slave     cpu,
  sram_bank_ctrl_if.slave     dma,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_ce_n,
  output logic                ram_w_n,
  output logic [DATA_W-1:0]   ram_d,
  input  logic [DATA_W-1:0]   ram_q
);

  localparam logic [ADDR_W-1:0] CNT_LAST    = '1;
  localparam state_t            RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;

  state_t            state_reg, state_next;
  gnt_t              last_grant_reg, last_grant_next, arb_grant;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next, sel_addr;
  logic              ram_ce_n_reg, ram_ce_n_next;
  logic              ram_w_n_reg, ram_w_n_next;
  logic [DATA_W-1:0] ram_d_reg, ram_d_next, sel_wdata;
  logic              busy_reg, sel_we;

  rr_arbiter2 u_arb (
    .req        ({dma.req, cpu.req}),
    .last_grant (last_grant_reg),
    .grant      (arb_grant)
  );

  assign sel_we    = (arb_grant == GNT_DMA) ? dma.we    : cpu.we;
  assign sel_addr  = (arb_grant == GNT_DMA) ? dma.addr  : cpu.addr;
  assign sel_wdata = (arb_grant == GNT_DMA) ? dma.wdata : cpu.wdata;

  // Pin values are registered from the next state, so the strobes line up with WR/RD1/RD2.
  // The sweep launches one word per INIT cycle; pins carry it one cycle later.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    ram_addr_next   = ram_addr_reg;
    ram_ce_n_next   = 1'b1;
    ram_w_n_next    = 1'b1;
    ram_d_next      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (init_start) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end else if (cpu.req || dma.req) begin
          last_grant_next = arb_grant;
          ram_addr_next   = sel_addr;
          ram_ce_n_next   = 1'b0;
          ram_w_n_next    = !sel_we;
          ram_d_next      = sel_we ? sel_wdata : '0;
          state_next      = sel_we ? ST_WR : ST_RD1;
        end
      end
      ST_INIT: begin
        ram_addr_next = cnt_reg;
        ram_ce_n_next = 1'b0;
        ram_w_n_next  = 1'b0;
        ram_d_next    = INIT_VALUE;
        cnt_next      = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) state_next = ST_IDLE;
      end
      ST_RD1: begin
        ram_ce_n_next = 1'b0;
        state_next    = ST_RD2;
      end
      ST_WR:   state_next = ST_DONE;
      ST_RD2:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RESET_STATE;
      cnt_reg        <= '0;
      last_grant_reg <= GNT_DMA;
      ram_addr_reg   <= '0;
      ram_ce_n_reg   <= 1'b1;
      ram_w_n_reg    <= 1'b1;
      ram_d_reg      <= '0;
      busy_reg       <= INIT_ON_RESET;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      ram_addr_reg   <= ram_addr_next;
      ram_ce_n_reg   <= ram_ce_n_next;
      ram_w_n_reg    <= ram_w_n_next;
      ram_d_reg      <= ram_d_next;
      busy_reg       <= (state_next == ST_INIT);
    end
  end

  // Index 0 is the CPU port, index 1 the DMA port, matching the grant encoding.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q <= (state_next == ST_DONE) && (int'(last_grant_reg) == gi);
        if (state_reg == ST_RD2 && int'(last_grant_reg) == gi) rdata_q <= ram_q;
      end
    end
  end

  assign cpu.ack   = g_port[0].ack_q;
  assign cpu.rdata = g_port[0].rdata_q;
  assign dma.ack   = g_port[1].ack_q;
  assign dma.rdata = g_port[1].rdata_q;

  assign init_busy = busy_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_ce_n  = ram_ce_n_reg;
  assign ram_w_n   = ram_w_n_reg;
  assign ram_d     = ram_d_reg;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with a bit-sliced synchronous SRAM bank model.
module tb_sram_bank_ctrl;
  import sram_ctrl_pkg::*;

  localparam int             AW    = 14;
  localparam int             DW    = 16;
  localparam int             DEPTH = 1 << AW;
  localparam logic [DW-1:0]  IV    = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_start;
  logic          init_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_ce_n;
  logic          ram_w_n;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  int checks = 0;
  int passes = 0;
  int cpu_ack_cnt = 0;
  int dma_ack_cnt = 0;
  bit ack_log[$];

  sram_bank_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  sram_bank_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

  sram_bank_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(IV), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .init_busy  (init_busy),
    .cpu        (cpu_if),
    .dma        (dma_if),
    .ram_addr   (ram_addr),
    .ram_ce_n   (ram_ce_n),
    .ram_w_n    (ram_w_n),
    .ram_d      (ram_d),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Bank model: DW one-bit synchronous slices sharing address and strobes.
  logic [DW-1:0] bank_mem [DEPTH];
  logic [DW-1:0] bank_q;
  always @(posedge clk) begin
    for (int b = 0; b < DW; b++) begin
      if (!ram_ce_n && !ram_w_n) bank_mem[ram_addr][b] <= ram_d[b];
      if (!ram_ce_n && ram_w_n)  bank_q[b] <= bank_mem[ram_addr][b];
    end
  end
  assign ram_q = (!ram_ce_n && ram_w_n) ? bank_q : '0;

  always @(negedge clk) begin
    if (cpu_if.ack === 1'b1) begin cpu_ack_cnt++; ack_log.push_back(1'b0); end
    if (dma_if.ack === 1'b1) begin dma_ack_cnt++; ack_log.push_back(1'b1); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  task automatic do_req(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                        output int cycles);
    cycles = 0;
    if (port) begin dma_if.req = 1; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata; end
    else      begin cpu_if.req = 1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; end
    while (cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      if ((port ? dma_if.ack : cpu_if.ack) === 1'b1) break;
    end
    rdata = port ? dma_if.rdata : cpu_if.rdata;
    if (port) dma_if.req = 0; else cpu_if.req = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_sweep(output int busy_cnt);
    busy_cnt = 0;
    while (init_busy === 1'b1 && busy_cnt < 20000) begin
      busy_cnt++;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int busy_cnt, errs, cyc;
    logic [DW-1:0] rd;
    reset = 1; init_start = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ram_ce_n !== 1'b1) $display("FAIL rst_ce_n: got %b want 1", ram_ce_n); else passes++;
    checks++; if (ram_w_n !== 1'b1) $display("FAIL rst_w_n: got %b want 1", ram_w_n); else passes++;
    checks++; if (ram_addr !== '0) $display("FAIL rst_addr: got %h want 0", ram_addr); else passes++;
    checks++; if (ram_d !== '0) $display("FAIL rst_d: got %h want 0", ram_d); else passes++;
    checks++; if ({cpu_if.ack, dma_if.ack} !== 2'b00) $display("FAIL rst_acks: got %b want 00", {cpu_if.ack, dma_if.ack}); else passes++;
    checks++; if (cpu_if.rdata !== '0 || dma_if.rdata !== '0) $display("FAIL rst_rdata: got %h/%h want 0/0", cpu_if.rdata, dma_if.rdata); else passes++;
    checks++; if (init_busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", init_busy); else passes++;
    reset = 0;
    wait_sweep(busy_cnt);
    checks++; if (busy_cnt != DEPTH) $display("FAIL sweep_len: got %0d want %0d", busy_cnt, DEPTH); else passes++;
    errs = 0;
    for (int a = 0; a < DEPTH; a++) if (bank_mem[a] !== IV) errs++;
    checks++; if (errs != 0) $display("FAIL sweep_contents: got %0d bad words want 0", errs); else passes++;
    do_req(1'b0, 1'b0, 14'h3FFF, '0, rd, cyc);
    checks++; if (rd !== IV) $display("FAIL sweep_read: got %h want %h", rd, IV); else passes++;
    $display("test_reset: sweep %0d cycles, read 3FFF=%h", busy_cnt, rd);
  endtask

  task automatic test_cpu_rw();
    int cyc, d0;
    logic [DW-1:0] rd;
    d0 = dma_ack_cnt;
    do_req(1'b0, 1'b1, 14'h0010, 16'h1234, rd, cyc);
    checks++; if (cyc != 2) $display("FAIL cpu_wr_latency: got %0d want 2", cyc); else passes++;
    do_req(1'b0, 1'b0, 14'h0010, '0, rd, cyc);
    checks++; if (cyc != 3) $display("FAIL cpu_rd_latency: got %0d want 3", cyc); else passes++;
    checks++; if (rd !== 16'h1234) $display("FAIL cpu_rdata: got %h want 1234", rd); else passes++;
    checks++; if (dma_ack_cnt != d0) $display("FAIL cpu_no_dma_ack: got %0d want %0d", dma_ack_cnt, d0); else passes++;
    $display("test_cpu_rw: read 0010=%h in %0d cycles", rd, cyc);
  endtask

  task automatic test_dma_hold();
    int cyc_c, cyc_d;
    logic [DW-1:0] rd_c, rd_d;
    ack_log.delete();
    fork
      do_req(1'b1, 1'b0, 14'h3FFF, '0, rd_d, cyc_d);
      do_req(1'b0, 1'b0, 14'h0010, '0, rd_c, cyc_c);
    join
    checks++; if (ack_log.size() != 2) $display("FAIL hold_ack_count: got %0d want 2", ack_log.size()); else passes++;
    checks++; if (ack_log.size() != 2 || ack_log[0] != 1'b1 || ack_log[1] != 1'b0) $display("FAIL hold_order: got %0d acks want DMA then CPU", ack_log.size()); else passes++;
    checks++; if (rd_d !== IV) $display("FAIL hold_dma_rdata: got %h want %h", rd_d, IV); else passes++;
    checks++; if (rd_c !== 16'h1234) $display("FAIL hold_cpu_rdata: got %h want 1234", rd_c); else passes++;
    checks++; if (cyc_d != 3 || cyc_c != 7) $display("FAIL hold_latency: got dma %0d cpu %0d want 3 7", cyc_d, cyc_c); else passes++;
    $display("test_dma_hold: dma %0d cycles, cpu %0d cycles", cyc_d, cyc_c);
  endtask

  task automatic test_init_mid();
    int busy_cnt, cyc_d, errs;
    logic [DW-1:0] rd;
    init_start = 1;
    @(posedge clk); #1;
    init_start = 0;
    busy_cnt = 0;
    fork
      begin
        repeat (100) @(posedge clk);
        #1;
        do_req(1'b1, 1'b1, 14'h0020, 16'hBEEF, rd, cyc_d);
      end
      begin
        while (init_busy === 1'b1 && busy_cnt < 20000) begin
          busy_cnt++;
          init_start = (busy_cnt == 8000);
          @(posedge clk); #1;
        end
        init_start = 0;
      end
    join
    checks++; if (busy_cnt != DEPTH) $display("FAIL mid_sweep_len: got %0d want %0d", busy_cnt, DEPTH); else passes++;
    checks++; if (cyc_d != DEPTH - 98) $display("FAIL mid_dma_wait: got %0d want %0d", cyc_d, DEPTH - 98); else passes++;
    checks++; if (bank_mem[14'h0020] !== 16'hBEEF) $display("FAIL mid_dma_write: got %h want beef", bank_mem[14'h0020]); else passes++;
    errs = 0;
    for (int a = 0; a < DEPTH; a++) if (a != 'h20 && bank_mem[a] !== IV) errs++;
    checks++; if (errs != 0) $display("FAIL mid_sweep_contents: got %0d bad words want 0", errs); else passes++;
    $display("test_init_mid: sweep %0d cycles, dma waited %0d", busy_cnt, cyc_d);
  endtask

  task automatic test_reset_rd2();
    int c0, busy_cnt;
    c0 = cpu_ack_cnt;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 14'h0040;
    repeat (2) @(posedge clk);
    #3;
    reset = 1;
    #1;
    checks++; if (ram_ce_n !== 1'b1) $display("FAIL rd2_ce_n_async: got %b want 1", ram_ce_n); else passes++;
    checks++; if (init_busy !== 1'b1) $display("FAIL rd2_busy: got %b want 1", init_busy); else passes++;
    cpu_if.req = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    checks++; if ({ram_ce_n, ram_w_n, ram_addr, ram_d} !== {2'b00, 14'h0000, IV}) $display("FAIL rd2_sweep_first: got ce %b w %b addr %h d %h want 0 0 0000 %h", ram_ce_n, ram_w_n, ram_addr, ram_d, IV); else passes++;
    @(posedge clk); #1;
    checks++; if (ram_addr !== 14'h0001) $display("FAIL rd2_sweep_second: got %h want 0001", ram_addr); else passes++;
    wait_sweep(busy_cnt);
    checks++; if (cpu_ack_cnt != c0) $display("FAIL rd2_no_ack: got %0d acks want %0d", cpu_ack_cnt, c0); else passes++;
    $display("test_reset_rd2: sweep restarted, remaining %0d cycles", busy_cnt);
  endtask

  task automatic test_arbitration();
    int cyc_c, cyc_d;
    logic [DW-1:0] rd_c, rd_d;
    ack_log.delete();
    for (int r = 0; r < 4; r++) begin
      fork
        do_req(1'b0, 1'b1, AW'(14'h0100 + r), DW'(16'hC000 + r), rd_c, cyc_c);
        do_req(1'b1, 1'b1, AW'(14'h0200 + r), DW'(16'hD000 + r), rd_d, cyc_d);
      join
      if (r == 0) begin
        checks++; if (cyc_c != 2 || cyc_d != 5) $display("FAIL arb_latency: got cpu %0d dma %0d want 2 5", cyc_c, cyc_d); else passes++;
      end
      $display("test_arbitration: round %0d cpu %0d dma %0d cycles", r, cyc_c, cyc_d);
    end
    checks++; if (ack_log.size() != 8) $display("FAIL arb_ack_count: got %0d want 8", ack_log.size()); else passes++;
    for (int i = 0; i < ack_log.size() && i < 8; i++) begin
      checks++; if (ack_log[i] != i[0]) $display("FAIL arb_order_%0d: got %0d want %0d", i, ack_log[i], i[0]); else passes++;
    end
    checks++; if (bank_mem[14'h0100] !== 16'hC000 || bank_mem[14'h0203] !== 16'hD003) $display("FAIL arb_data: got %h %h want c000 d003", bank_mem[14'h0100], bank_mem[14'h0203]); else passes++;
  endtask

  initial begin
    reset = 1; init_start = 0;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dma_if.req = 0; dma_if.we = 0; dma_if.addr = '0; dma_if.wdata = '0;
    test_reset();
    test_cpu_rw();
    test_dma_hold();
    test_init_mid();
    test_reset_rd2();
    test_arbitration();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
